lcd_hd44780_ctrl: RTL and testbench

- Parametrised successor of the Spartan-3E character-LCD controller, driving an HD44780-compatible panel in 4-bit mode.
- Runs the full power-on init sequence autonomously, then the configuration bytes, then accepts arbitrary command/data bytes over a valid/ready port.
- Each byte is split into two nibbles, strobed with programmable timing, followed by a command-dependent busy wait.
- Sits between the text/cursor logic and the LCD pins; owns all LCD timing.

---
 rtl/lcd_pkg.sv | 49 ++++
 rtl/lcd_nibble_strobe.sv | 87 ++++++++
 rtl/lcd_hd44780_ctrl.sv | 169 ++++++++++++++++
 tb/tb_lcd_hd44780_ctrl.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: state encodings, init nibbles and
// configuration ROM for the HD44780 controller.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT_NIB,
        INIT_WAIT,
        HI_NIB,
        GAP,
        LO_NIB,
        POST_WAIT,
        IDLE
    } ctrlState_e;

    typedef enum logic [1:0] {
        STB_IDLE,
        STB_SETUP,
        STB_PULSE,
        STB_HOLD
    } strobeState_e;

    localparam logic [3:0] INIT_NIB_WAKE = 4'h3;
    localparam logic [3:0] INIT_NIB_4BIT = 4'h2;
    localparam logic [7:0] OP_CLEAR = 8'h01;
    localparam logic [7:0] OP_HOME = 8'h02;
    localparam int CFG_LEN = 4;

    function automatic logic [7:0] cfgByte(input logic [1:0] idx);
        case (idx)
            2'd0: return 8'h28;
            2'd1: return 8'h06;
            2'd2: return 8'h0C;
            default: return 8'h01;
        endcase
    endfunction

    function automatic logic [3:0] initNibble(input logic [1:0] step);
        return (step == 2'd3) ? INIT_NIB_4BIT : INIT_NIB_WAKE;
    endfunction

    // Clear and home need the long post-byte wait.
    function automatic logic isLongCmd(input logic rs,
                                       input logic [7:0] data);
        return !rs && (data[7:1] == OP_CLEAR[7:1] ||
                       data[7:1] == OP_HOME[7:1]);
    endfunction

endpackage

// File: rtl/lcd_nibble_strobe.sv
// lcd_nibble_strobe: drives one nibble onto the
// pins with setup, E pulse and hold timing.
module lcd_nibble_strobe
    import lcd_pkg::*;
#(
    parameter int SETUP_CYCLES   = 2,
    parameter int E_PULSE_CYCLES = 12,
    parameter int HOLD_CYCLES    = 2
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iStart,
    input  logic [3:0] iNibble,
    input  logic       iRS,
    output logic       oE,
    output logic [3:0] oData,
    output logic       oRS,
    output logic       oDone
);

    localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYCLES - 1);
    localparam logic [15:0] PULSE_LAST = 16'(E_PULSE_CYCLES - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(HOLD_CYCLES - 1);

    strobeState_e phase, phaseNext;
    logic [15:0]  count, countNext;
    logic         eNext, rsNext;
    logic [3:0]   dataNext;

    // Phase, counter and pin registers.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            phase <= STB_IDLE;
            count <= '0;
            oE    <= 1'b0;
            oData <= '0;
            oRS   <= 1'b0;
        end else begin
            phase <= phaseNext;
            count <= countNext;
            oE    <= eNext;
            oData <= dataNext;
            oRS   <= rsNext;
        end
    end

    // Step through setup, pulse and hold phases.
    always_comb begin
        phaseNext = phase;
        countNext = count + 16'd1;
        eNext     = oE;
        dataNext  = oData;
        rsNext    = oRS;
        oDone     = 1'b0;
        unique case (phase)
            STB_IDLE: begin
                countNext = '0;
                if (iStart) begin
                    phaseNext = STB_SETUP;
                    dataNext  = iNibble;
                    rsNext    = iRS;
                    eNext     = 1'b0;
                end
            end
            STB_SETUP: if (count == SETUP_LAST) begin
                phaseNext = STB_PULSE;
                countNext = '0;
                eNext     = 1'b1;
            end
            STB_PULSE: if (count == PULSE_LAST) begin
                phaseNext = STB_HOLD;
                countNext = '0;
                eNext     = 1'b0;
            end
            STB_HOLD: if (count == HOLD_LAST) begin
                phaseNext = STB_IDLE;
                countNext = '0;
                oDone     = 1'b1;
            end
            default: begin
                phaseNext = STB_IDLE;
                eNext     = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// lcd_hd44780_ctrl: 4-bit HD44780 controller with
// autonomous init, config bytes and a byte port.
module lcd_hd44780_ctrl
    import lcd_pkg::*;
#(
    parameter int POWERON_CYCLES = 750000,
    parameter int INIT_WAIT1     = 205000,
    parameter int INIT_WAIT2     = 5000,
    parameter int INIT_WAIT3     = 2000,
    parameter int SETUP_CYCLES   = 2,
    parameter int E_PULSE_CYCLES = 12,
    parameter int HOLD_CYCLES    = 2,
    parameter int NIBBLE_GAP     = 50,
    parameter int CMD_WAIT       = 2000,
    parameter int CLEAR_WAIT     = 82000,
    parameter int CNT_W          = 32
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iCmdValid,
    input  logic       iCmdRS,
    input  logic [7:0] iCmdData,
    output logic       oCmdReady,
    output logic       oInitDone,
    output logic       oLCD_Enabled,
    output logic       oLCD_RegisterSelect,
    output logic       oLCD_ReadWrite,
    output logic       oLCD_StrataFlashControl,
    output logic [3:0] oLCD_Data
);

    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(POWERON_CYCLES - 1);
    localparam logic [CNT_W-1:0] W1_LAST  = CNT_W'(INIT_WAIT1 - 1);
    localparam logic [CNT_W-1:0] W2_LAST  = CNT_W'(INIT_WAIT2 - 1);
    localparam logic [CNT_W-1:0] W3_LAST  = CNT_W'(INIT_WAIT3 - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(NIBBLE_GAP - 1);
    localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_WAIT - 1);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLEAR_WAIT - 1);

    ctrlState_e       state, stateNext;
    logic [CNT_W-1:0] timer, waitLast;
    logic [1:0]       step, stepNext, cfgIdx, cfgNext;
    logic [7:0]       curByte, byteNext;
    logic             curRs, rsNext, doneNext;
    logic             stbStart, stbLo, stbInit, stbRs, stbDone;
    logic [3:0]       stbNib;

    assign oLCD_ReadWrite          = 1'b0;
    assign oLCD_StrataFlashControl = 1'b1;

    // State, wait timer, current byte and status flags.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state     <= PWR_WAIT;
            timer     <= '0;
            step      <= '0;
            cfgIdx    <= '0;
            curByte   <= '0;
            curRs     <= 1'b0;
            oInitDone <= 1'b0;
            oCmdReady <= 1'b0;
        end else begin
            state     <= stateNext;
            if (stateNext != state)
                timer <= '0;
            else if (timer != '1)
                timer <= timer + CNT_W'(1);
            step      <= stepNext;
            cfgIdx    <= cfgNext;
            curByte   <= byteNext;
            curRs     <= rsNext;
            oInitDone <= doneNext;
            oCmdReady <= (stateNext == IDLE);
        end
    end

    // Sequencing and selection of the next nibble.
    always_comb begin
        stateNext = state;
        stepNext  = step;
        cfgNext   = cfgIdx;
        byteNext  = curByte;
        rsNext    = curRs;
        doneNext  = oInitDone;
        stbStart  = 1'b0;
        stbLo     = 1'b0;
        stbInit   = 1'b0;
        waitLast  = '0;
        unique case (state)
            PWR_WAIT: if (timer == PWR_LAST) begin
                stateNext = INIT_NIB;
                stepNext  = '0;
                stbStart  = 1'b1;
                stbInit   = 1'b1;
            end
            INIT_NIB: if (stbDone) stateNext = INIT_WAIT;
            INIT_WAIT: begin
                unique case (step)
                    2'd0:    waitLast = W1_LAST;
                    2'd1:    waitLast = W2_LAST;
                    default: waitLast = W3_LAST;
                endcase
                if (timer == waitLast) begin
                    stbStart = 1'b1;
                    if (step != 2'd3) begin
                        stateNext = INIT_NIB;
                        stepNext  = step + 2'd1;
                        stbInit   = 1'b1;
                    end else begin
                        stateNext = HI_NIB;
                        cfgNext   = '0;
                        byteNext  = cfgByte(2'd0);
                        rsNext    = 1'b0;
                    end
                end
            end
            HI_NIB: if (stbDone) stateNext = GAP;
            GAP: if (timer == GAP_LAST) begin
                stateNext = LO_NIB;
                stbStart  = 1'b1;
                stbLo     = 1'b1;
            end
            LO_NIB: if (stbDone) stateNext = POST_WAIT;
            POST_WAIT: begin
                waitLast = isLongCmd(curRs, curByte) ? CLR_LAST : CMD_LAST;
                if (timer == waitLast) begin
                    if (oInitDone || cfgIdx == 2'(CFG_LEN - 1)) begin
                        stateNext = IDLE;
                        doneNext  = 1'b1;
                    end else begin
                        stateNext = HI_NIB;
                        cfgNext   = cfgIdx + 2'd1;
                        byteNext  = cfgByte(cfgIdx + 2'd1);
                        rsNext    = 1'b0;
                        stbStart  = 1'b1;
                    end
                end
            end
            IDLE: if (iCmdValid && oCmdReady) begin
                stateNext = HI_NIB;
                byteNext  = iCmdData;
                rsNext    = iCmdRS;
                stbStart  = 1'b1;
            end
            default: stateNext = PWR_WAIT;
        endcase
        stbNib = stbLo ? curByte[3:0] : byteNext[7:4];
        if (stbInit)
            stbNib = initNibble(stepNext);
        stbRs = stbInit ? 1'b0 : rsNext;
    end

    lcd_nibble_strobe #(
        .SETUP_CYCLES  (SETUP_CYCLES),
        .E_PULSE_CYCLES(E_PULSE_CYCLES),
        .HOLD_CYCLES   (HOLD_CYCLES)
    ) uStrobe (
        .Clock  (Clock),
        .Reset  (Reset),
        .iStart (stbStart),
        .iNibble(stbNib),
        .iRS    (stbRs),
        .oE     (oLCD_Enabled),
        .oData  (oLCD_Data),
        .oRS    (oLCD_RegisterSelect),
        .oDone  (stbDone)
    );

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// tb_lcd_hd44780_ctrl: randomized bench with an
// edge-timeline reference model of the LCD pins.
module tb_lcd_hd44780_ctrl;

    localparam int PWR = 100, W1 = 40, W2 = 20, W3 = 10;
    localparam int CMDW = 30, CLRW = 200, GAPC = 5;
    localparam int SU = 2, EP = 12, HD = 2;
    localparam int STB = SU + EP + HD;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       iCmdValid = 1'b0;
    logic       iCmdRS = 1'b0;
    logic [7:0] iCmdData = 8'h00;
    logic       oCmdReady, oInitDone, oLCD_Enabled;
    logic       oLCD_RegisterSelect, oLCD_ReadWrite;
    logic       oLCD_StrataFlashControl;
    logic [3:0] oLCD_Data;

    int vectors = 0;
    int miscompares = 0;
    int rel = 0;

    int         actRise[$], actFall[$], actReady[$];
    logic [3:0] actNib[$];
    logic       actRs[$];
    int         expRise[$], expFall[$], expReady[$];
    logic [3:0] expNib[$];
    logic       expRs[$];
    int         doneRise = -1;
    bit         unstable = 1'b0;
    bit         clrReq = 1'b0;
    bit         clrSeen = 1'b0;
    logic       prevE, prevReady, prevDone, curRs;
    logic [3:0] curNib;

    lcd_hd44780_ctrl #(
        .POWERON_CYCLES(PWR), .INIT_WAIT1(W1), .INIT_WAIT2(W2),
        .INIT_WAIT3(W3), .CMD_WAIT(CMDW), .CLEAR_WAIT(CLRW),
        .NIBBLE_GAP(GAPC)
    ) dut (
        .Clock(Clock), .Reset(Reset),
        .iCmdValid(iCmdValid), .iCmdRS(iCmdRS), .iCmdData(iCmdData),
        .oCmdReady(oCmdReady), .oInitDone(oInitDone),
        .oLCD_Enabled(oLCD_Enabled),
        .oLCD_RegisterSelect(oLCD_RegisterSelect),
        .oLCD_ReadWrite(oLCD_ReadWrite),
        .oLCD_StrataFlashControl(oLCD_StrataFlashControl),
        .oLCD_Data(oLCD_Data)
    );

    always #5 Clock = ~Clock;

    // Count non-reset edges since the last reset edge.
    always @(posedge Clock) rel <= Reset ? rel + 1 : 0;

    // Record strobes, ready and done rises on the pins.
    always @(negedge Clock) begin
        if (clrReq != clrSeen) begin
            actRise.delete(); actFall.delete(); actReady.delete();
            actNib.delete(); actRs.delete();
            doneRise <= -1;
            unstable <= 1'b0;
            clrSeen <= clrReq;
        end
        if (oLCD_Enabled === 1'b1 && prevE !== 1'b1) begin
            actRise.push_back(rel);
            actNib.push_back(oLCD_Data);
            actRs.push_back(oLCD_RegisterSelect);
            curNib <= oLCD_Data;
            curRs <= oLCD_RegisterSelect;
        end else if (oLCD_Enabled === 1'b1 &&
                     (oLCD_Data !== curNib ||
                      oLCD_RegisterSelect !== curRs))
            unstable <= 1'b1;
        if (oLCD_Enabled !== 1'b1 && prevE === 1'b1)
            actFall.push_back(rel);
        if (oCmdReady === 1'b1 && prevReady !== 1'b1)
            actReady.push_back(rel);
        if (oInitDone === 1'b1 && prevDone !== 1'b1)
            doneRise <= rel;
        prevE <= oLCD_Enabled;
        prevReady <= oCmdReady;
        prevDone <= oInitDone;
    end

    task automatic tick();
        @(negedge Clock);
        #1;
    endtask

    task automatic clear_monitor();
        expRise.delete(); expFall.delete(); expReady.delete();
        expNib.delete(); expRs.delete();
        clrReq = !clrReq;
        tick();
    endtask

    task automatic push_strobe(input int s, input logic [3:0] n,
                               input logic rs);
        expRise.push_back(s + SU);
        expFall.push_back(s + SU + EP);
        expNib.push_back(n);
        expRs.push_back(rs);
    endtask

    task automatic model_byte(input int a, input logic [7:0] d,
                              input logic rs, output int e);
        int lo;
        int post;
        post = (rs == 1'b0 && d < 8'h04) ? CLRW : CMDW;
        push_strobe(a, d[7:4], rs);
        lo = a + STB + GAPC;
        push_strobe(lo, d[3:0], rs);
        e = lo + STB + post;
    endtask

    task automatic model_init(output int e);
        int s;
        int w[4];
        logic [3:0] n[4];
        logic [7:0] cfg[4];
        w = '{W1, W2, W3, W3};
        n = '{4'h3, 4'h3, 4'h3, 4'h2};
        cfg = '{8'h28, 8'h06, 8'h0C, 8'h01};
        s = PWR;
        for (int k = 0; k < 4; k++) begin
            push_strobe(s, n[k], 1'b0);
            s = s + STB + w[k];
        end
        for (int c = 0; c < 4; c++) model_byte(s, cfg[c], 1'b0, s);
        e = s;
    endtask

    task automatic check_queues(input string tag);
        vectors++;
        if (actRise.size() !== expRise.size()) begin
            miscompares++;
            $display("FAIL %s strobe count: got %0d want %0d",
                     tag, actRise.size(), expRise.size());
        end
        for (int i = 0; i < actRise.size() && i < expRise.size(); i++) begin
            vectors++;
            if (actRise[i] !== expRise[i]) begin
                miscompares++;
                $display("FAIL %s E rise #%0d: got edge %0d want %0d",
                         tag, i, actRise[i], expRise[i]);
            end
            vectors++;
            if (actNib[i] !== expNib[i]) begin
                miscompares++;
                $display("FAIL %s nibble #%0d: got %h want %h",
                         tag, i, actNib[i], expNib[i]);
            end
            vectors++;
            if (actRs[i] !== expRs[i]) begin
                miscompares++;
                $display("FAIL %s RS #%0d: got %b want %b",
                         tag, i, actRs[i], expRs[i]);
            end
        end
        vectors++;
        if (actFall.size() !== expFall.size()) begin
            miscompares++;
            $display("FAIL %s E fall count: got %0d want %0d",
                     tag, actFall.size(), expFall.size());
        end
        for (int i = 0; i < actFall.size() && i < expFall.size(); i++) begin
            vectors++;
            if (actFall[i] !== expFall[i]) begin
                miscompares++;
                $display("FAIL %s E fall #%0d: got edge %0d want %0d",
                         tag, i, actFall[i], expFall[i]);
            end
        end
        vectors++;
        if (actReady.size() !== expReady.size()) begin
            miscompares++;
            $display("FAIL %s ready rise count: got %0d want %0d",
                     tag, actReady.size(), expReady.size());
        end
        for (int i = 0; i < actReady.size() && i < expReady.size(); i++) begin
            vectors++;
            if (actReady[i] !== expReady[i]) begin
                miscompares++;
                $display("FAIL %s ready rise #%0d: got edge %0d want %0d",
                         tag, i, actReady[i], expReady[i]);
            end
        end
        vectors++;
        if (unstable !== 1'b0) begin
            miscompares++;
            $display("FAIL %s data/RS changed while E high: got 1 want 0",
                     tag);
        end
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (oCmdReady === 1'b1) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL %s ready timeout: got 0 want 1", tag);
    endtask

    task automatic send(input logic [7:0] d, input logic rs,
                        output int acc);
        wait_ready("send");
        iCmdValid = 1'b1;
        iCmdData = d;
        iCmdRS = rs;
        acc = rel + 1;
        tick();
        iCmdValid = 1'b0;
        vectors++;
        if (oCmdReady !== 1'b0) begin
            miscompares++;
            $display("FAIL ready after accept: got %b want 0", oCmdReady);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        repeat (5) tick();
        vectors++;
        if (oLCD_Enabled !== 1'b0) begin
            miscompares++;
            $display("FAIL reset E: got %b want 0", oLCD_Enabled);
        end
        vectors++;
        if (oLCD_Data !== 4'h0) begin
            miscompares++;
            $display("FAIL reset data: got %h want 0", oLCD_Data);
        end
        vectors++;
        if (oLCD_RegisterSelect !== 1'b0) begin
            miscompares++;
            $display("FAIL reset RS: got %b want 0", oLCD_RegisterSelect);
        end
        vectors++;
        if (oCmdReady !== 1'b0 || oInitDone !== 1'b0) begin
            miscompares++;
            $display("FAIL reset ready/done: got %b%b want 00",
                     oCmdReady, oInitDone);
        end
        vectors++;
        if (oLCD_ReadWrite !== 1'b0 || oLCD_StrataFlashControl !== 1'b1) begin
            miscompares++;
            $display("FAIL reset RW/SF: got %b%b want 01",
                     oLCD_ReadWrite, oLCD_StrataFlashControl);
        end
        clear_monitor();
    endtask

    task automatic test_init();
        int e;
        bit seen;
        model_init(e);
        expReady.push_back(e);
        Reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (oInitDone === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        vectors++;
        if (!seen || doneRise !== e) begin
            miscompares++;
            $display("FAIL init done edge: got %0d want %0d", doneRise, e);
        end
        check_queues("init");
        clear_monitor();
    endtask

    task automatic test_data_write();
        int a, e;
        send(8'h41, 1'b1, a);
        model_byte(a, 8'h41, 1'b1, e);
        expReady.push_back(e);
        wait_ready("data");
        check_queues("data 41");
        clear_monitor();
    endtask

    task automatic test_back_to_back();
        int a1, a2, e1, e2, got;
        wait_ready("b2b");
        iCmdValid = 1'b1;
        iCmdData = 8'h01;
        iCmdRS = 1'b0;
        a1 = rel + 1;
        tick();
        iCmdData = 8'h80;
        model_byte(a1, 8'h01, 1'b0, e1);
        a2 = e1 + 1;
        model_byte(a2, 8'h80, 1'b0, e2);
        expReady.push_back(e1);
        expReady.push_back(e2);
        got = -1;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (oCmdReady === 1'b1) begin
                got = rel + 1;
                break;
            end
        end
        vectors++;
        if (got !== a2) begin
            miscompares++;
            $display("FAIL b2b accept edge: got %0d want %0d", got, a2);
        end
        tick();
        iCmdValid = 1'b0;
        wait_ready("b2b");
        check_queues("back to back");
        clear_monitor();
    endtask

    task automatic test_busy_ignore();
        int a, e;
        logic [7:0] d;
        d = 8'($urandom);
        send(d, 1'b1, a);
        model_byte(a, d, 1'b1, e);
        expReady.push_back(e);
        repeat (8) tick();
        iCmdValid = 1'b1;
        iCmdData = 8'hFF;
        iCmdRS = 1'b0;
        repeat (2) tick();
        iCmdValid = 1'b0;
        repeat (40) tick();
        iCmdValid = 1'b1;
        tick();
        iCmdValid = 1'b0;
        wait_ready("busy");
        repeat (60) tick();
        check_queues("busy ignore");
        clear_monitor();
    endtask

    task automatic test_random();
        int a, e;
        logic [7:0] d;
        logic rs;
        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                d = 8'($urandom_range(0, 3));
                rs = 1'b0;
            end else begin
                d = 8'($urandom);
                rs = 1'($urandom_range(0, 1));
            end
            repeat ($urandom_range(0, 3)) tick();
            send(d, rs, a);
            model_byte(a, d, rs, e);
            expReady.push_back(e);
        end
        wait_ready("random");
        check_queues("random");
        clear_monitor();
    endtask

    task automatic test_reset_mid();
        int a;
        bit found;
        send(8'($urandom), 1'b1, a);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (oLCD_Enabled === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        vectors++;
        if (!found || oInitDone !== 1'b1) begin
            miscompares++;
            $display("FAIL mid E high/done: got %b%b want 11",
                     found, oInitDone);
        end
        Reset = 1'b0;
        tick();
        vectors++;
        if (oLCD_Enabled !== 1'b0 || oLCD_Data !== 4'h0) begin
            miscompares++;
            $display("FAIL mid reset E/data: got %b/%h want 0/0",
                     oLCD_Enabled, oLCD_Data);
        end
        vectors++;
        if (oInitDone !== 1'b0 || oCmdReady !== 1'b0) begin
            miscompares++;
            $display("FAIL mid reset done/ready: got %b%b want 00",
                     oInitDone, oCmdReady);
        end
        clear_monitor();
        test_init();
    endtask

    initial begin
        test_reset();
        test_init();
        test_data_write();
        test_back_to_back();
        test_busy_ignore();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
